// File: rtl/int_pkg.sv
// Shared types for the interrupt request collector: queue entry layout and
// per-source configuration word.
package int_pkg;

    localparam logic [3:0] INT_PRI_MAX = 4'd15;

    typedef struct packed {
        logic [3:0]  pri;
        logic [7:0]  vector;
        logic [10:0] rsvd;
        logic [4:0]  src;
    } int_entry_t;

    typedef struct packed {
        logic       en;
        logic       lvl;
        logic [3:0] pri;
        logic [7:0] vector;
    } int_cfg_t;

endpackage

// File: rtl/int_pri_rr_arb.sv
// Combinational finder: highest priority pending source, ties broken by the
// first index at or after the round-robin pointer.
module int_pri_rr_arb #(
    parameter int NSRC = 16,
    parameter int SRCW = 5
) (
    input  logic [NSRC-1:0]      pend,
    input  logic [NSRC-1:0][3:0] pri,
    input  logic [SRCW-1:0]      rr,
    output logic                 valid,
    output logic [SRCW-1:0]      win
);

    logic [3:0] best;

    // Scanning from rr with a strict '>' keeps the earliest equal-priority hit.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        best  = '0;
        for (int i = 0; i < NSRC; i++) begin
            int idx;
            idx = int'(rr) + i;
            if (idx >= NSRC) idx = idx - NSRC;
            if (pend[idx] && (!valid || pri[idx] > best)) begin
                valid = 1'b1;
                best  = pri[idx];
                win   = SRCW'(idx);
            end
        end
    end

endmodule

// File: rtl/int_req_collector.sv
// Interrupt request collector: detects edge/level requests, holds them pending,
// arbitrates and posts one entry per cycle to the downstream int_queue.
module int_req_collector
    import int_pkg::*;
#(
    parameter int NSRC = 16,
    parameter int SRCW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq,
    input  logic            cfg_wr,
    input  logic [SRCW-1:0] cfg_src,
    input  logic [13:0]     cfg_dat,
    input  logic            eoi,
    input  logic [SRCW-1:0] eoi_src,
    input  logic            full,
    output logic            wr,
    output logic [27:0]     o,
    output logic [NSRC-1:0] pend
);

    int_cfg_t              cfg [NSRC];
    int_cfg_t              new_cfg;
    logic [NSRC-1:0]       posted, prev;
    logic [SRCW-1:0]       rr, win;
    logic                  valid, post;
    logic [NSRC-1:0][3:0]  pri_v;
    logic [NSRC-1:0]       set_v, hit_v, dis_v, eoi_v;
    int_entry_t            ent;

    assign new_cfg = int_cfg_t'(cfg_dat);

    int_pri_rr_arb #(.NSRC(NSRC), .SRCW(SRCW)) u_arb (
        .pend  (pend),
        .pri   (pri_v),
        .rr    (rr),
        .valid (valid),
        .win   (win)
    );

    // Out-of-range cfg_src / eoi_src never match any s, so they are ignored.
    always_comb begin
        post  = valid && !full;
        ent   = '0;
        pri_v = '0;
        set_v = '0;
        hit_v = '0;
        dis_v = '0;
        eoi_v = '0;
        for (int s = 0; s < NSRC; s++) begin
            pri_v[s] = cfg[s].pri;
            hit_v[s] = post && (win == SRCW'(s));
            dis_v[s] = cfg_wr && (cfg_src == SRCW'(s)) && !new_cfg.en;
            eoi_v[s] = eoi && (eoi_src == SRCW'(s));
            // A level source being posted this cycle is already in service,
            // otherwise a held line would immediately re-pend.
            set_v[s] = cfg[s].en && irq[s] &&
                       (cfg[s].lvl ? !(posted[s] || hit_v[s]) : !prev[s]);
            if (win == SRCW'(s)) begin
                ent.pri    = cfg[s].pri;
                ent.vector = cfg[s].vector;
            end
        end
        ent.src = 5'(win);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr     <= 1'b0;
            o      <= '0;
            pend   <= '0;
            posted <= '0;
            prev   <= '0;
            rr     <= '0;
            for (int s = 0; s < NSRC; s++) cfg[s] <= '0;
        end else begin
            wr   <= post;
            prev <= irq;
            if (post) begin
                o  <= ent;
                rr <= (int'(win) == NSRC - 1) ? '0 : win + 1'b1;
            end
            for (int s = 0; s < NSRC; s++) begin
                if (cfg_wr && cfg_src == SRCW'(s)) cfg[s] <= new_cfg;

                if (dis_v[s] || !cfg[s].en) pend[s] <= 1'b0;
                else if (set_v[s])          pend[s] <= 1'b1;
                else if (hit_v[s])          pend[s] <= 1'b0;

                if (dis_v[s])      posted[s] <= 1'b0;
                else if (hit_v[s]) posted[s] <= cfg[s].lvl;
                else if (eoi_v[s]) posted[s] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_int_req_collector.sv
// Scenario bench for int_req_collector: expected entries queued at stimulus
// time, popped and compared whenever the DUT asserts wr.
module tb_int_req_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] irq;
    logic        cfg_wr;
    logic [4:0]  cfg_src;
    logic [13:0] cfg_dat;
    logic        eoi;
    logic [4:0]  eoi_src;
    logic        full;
    logic        wr;
    logic [27:0] o;
    logic [15:0] pend;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    logic [27:0] sb [$];

    int_req_collector #(.NSRC(16), .SRCW(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .cfg_wr  (cfg_wr),
        .cfg_src (cfg_src),
        .cfg_dat (cfg_dat),
        .eoi     (eoi),
        .eoi_src (eoi_src),
        .full    (full),
        .wr      (wr),
        .o       (o),
        .pend    (pend)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every wr must match the oldest queued entry.
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            logic [27:0] exp;
            wr_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_wr got o=%h expected no write", o);
            end else begin
                exp = sb.pop_front();
                if (o !== exp) begin
                    failures++;
                    $display("FAIL sb_entry got o=%h expected %h", o, exp);
                end
            end
        end
    end

    function automatic logic [27:0] mk(input logic [3:0] p, input logic [7:0] v, input logic [4:0] s);
        return {p, v, 11'b0, s};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int src, input logic en, input logic lvl,
                          input logic [3:0] p, input logic [7:0] v);
        cfg_wr  = 1'b1;
        cfg_src = 5'(src);
        cfg_dat = {en, lvl, p, v};
        tick(1);
        cfg_wr  = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (wr !== 1'b0) begin failures++; $display("FAIL reset_wr got %b expected 0", wr); end
        checks++;
        if (o !== 28'h0) begin failures++; $display("FAIL reset_o got %h expected 0", o); end
        checks++;
        if (pend !== 16'h0) begin failures++; $display("FAIL reset_pend got %h expected 0", pend); end
    endtask

    task automatic test_edge;
        int c0 = wr_cnt;
        sb.push_back(mk(4'd5, 8'h21, 5'd3));
        irq[3] = 1'b1;
        tick(1);
        checks++;
        if (pend[3] !== 1'b1 || wr !== 1'b0) begin
            failures++; $display("FAIL edge_pend got pend3=%b wr=%b expected 1 0", pend[3], wr);
        end
        tick(1);
        checks++;
        if (wr !== 1'b1 || o !== 28'h5210003) begin
            failures++; $display("FAIL edge_post got wr=%b o=%h expected 1 5210003", wr, o);
        end
        irq[3] = 1'b0;
        tick(4);
        checks++;
        if (wr_cnt - c0 != 1) begin failures++; $display("FAIL edge_count got %0d expected 1", wr_cnt - c0); end
    endtask

    task automatic test_level;
        int c0 = wr_cnt;
        bit got = 0;
        sb.push_back(mk(4'd9, 8'h40, 5'd7));
        irq[7] = 1'b1;
        tick(8);
        checks++;
        if (wr_cnt - c0 != 1 || pend[7] !== 1'b0) begin
            failures++; $display("FAIL level_once got cnt=%0d pend7=%b expected 1 0", wr_cnt - c0, pend[7]);
        end
        sb.push_back(mk(4'd9, 8'h40, 5'd7));
        eoi = 1'b1; eoi_src = 5'd7;
        tick(1);
        eoi = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            tick(1);
            if (wr === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL level_eoi_repost got none expected wr within bound"); end
        irq[7] = 1'b0;
        tick(2);
        eoi = 1'b1; eoi_src = 5'd7;
        tick(1);
        eoi = 1'b0;
        tick(4);
        checks++;
        if (wr_cnt - c0 != 2) begin failures++; $display("FAIL level_count got %0d expected 2", wr_cnt - c0); end
    endtask

    task automatic test_priority;
        sb.push_back(mk(4'd12, 8'hA0, 5'd10));
        sb.push_back(mk(4'd2, 8'h11, 5'd1));
        irq[1] = 1'b1; irq[10] = 1'b1;
        tick(1);
        irq[1] = 1'b0; irq[10] = 1'b0;
        checks++;
        if (pend !== 16'h0402) begin failures++; $display("FAIL prio_pend got %h expected 0402", pend); end
        for (int k = 0; k < 2; k++) begin
            tick(1);
            checks++;
            if (wr !== 1'b1) begin failures++; $display("FAIL prio_b2b cycle %0d got wr=%b expected 1", k, wr); end
        end
        tick(2);
        checks++;
        if (pend !== 16'h0) begin failures++; $display("FAIL prio_drain got %h expected 0", pend); end
    endtask

    task automatic test_rr;
        int c0 = wr_cnt;
        for (int r = 0; r < 2; r++) begin
            sb.push_back(mk(4'd4, 8'h22, 5'd2));
            sb.push_back(mk(4'd4, 8'h55, 5'd5));
            sb.push_back(mk(4'd4, 8'h99, 5'd9));
            irq[2] = 1'b1; irq[5] = 1'b1; irq[9] = 1'b1;
            tick(1);
            irq[2] = 1'b0; irq[5] = 1'b0; irq[9] = 1'b0;
            tick(5);
        end
        checks++;
        if (wr_cnt - c0 != 6 || pend !== 16'h0) begin
            failures++; $display("FAIL rr_count got cnt=%0d pend=%h expected 6 0000", wr_cnt - c0, pend);
        end
    endtask

    task automatic test_full;
        int c0 = wr_cnt;
        full = 1'b1;
        irq[1] = 1'b1; irq[3] = 1'b1; irq[10] = 1'b1;
        tick(1);
        irq[1] = 1'b0; irq[3] = 1'b0; irq[10] = 1'b0;
        tick(4);
        checks++;
        if (wr_cnt != c0 || pend !== 16'h040A) begin
            failures++; $display("FAIL full_hold got cnt=%0d pend=%h expected 0 040a", wr_cnt - c0, pend);
        end
        sb.push_back(mk(4'd12, 8'hA0, 5'd10));
        sb.push_back(mk(4'd5, 8'h21, 5'd3));
        sb.push_back(mk(4'd2, 8'h11, 5'd1));
        full = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checks++;
            if (wr !== 1'b1) begin failures++; $display("FAIL full_release cycle %0d got wr=%b expected 1", k, wr); end
        end
        tick(1);
        checks++;
        if (wr !== 1'b0 || pend !== 16'h0) begin
            failures++; $display("FAIL full_drain got wr=%b pend=%h expected 0 0000", wr, pend);
        end
    endtask

    task automatic test_cfg_disable;
        int c0 = wr_cnt;
        full = 1'b1;
        irq[4] = 1'b1;
        tick(1);
        irq[4] = 1'b0;
        checks++;
        if (pend[4] !== 1'b1) begin failures++; $display("FAIL dis_pend_set got %b expected 1", pend[4]); end
        do_cfg(4, 1'b0, 1'b0, 4'd3, 8'h44);
        full = 1'b0;
        tick(4);
        checks++;
        if (wr_cnt != c0 || pend[4] !== 1'b0) begin
            failures++; $display("FAIL dis_no_post got cnt=%0d pend4=%b expected 0 0", wr_cnt - c0, pend[4]);
        end
    endtask

    task automatic test_reset_mid;
        sb.push_back(mk(4'd12, 8'hA0, 5'd10));
        irq[10] = 1'b1; irq[3] = 1'b1;
        tick(1);
        irq[10] = 1'b0; irq[3] = 1'b0;
        tick(1);
        checks++;
        if (wr !== 1'b1 || pend[3] !== 1'b1) begin
            failures++; $display("FAIL rstmid_pre got wr=%b pend3=%b expected 1 1", wr, pend[3]);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if (wr !== 1'b0 || pend !== 16'h0) begin
            failures++; $display("FAIL rstmid_post got wr=%b pend=%h expected 0 0000", wr, pend);
        end
        rst = 1'b0;
        tick(2);
        checks++;
        if (o !== 28'h0) begin failures++; $display("FAIL rstmid_o got %h expected 0", o); end
    endtask

    initial begin
        rst = 1'b1; irq = '0; cfg_wr = 1'b0; cfg_src = '0; cfg_dat = '0;
        eoi = 1'b0; eoi_src = '0; full = 1'b0;
        tick(3);
        test_reset;
        rst = 1'b0;
        tick(1);
        do_cfg(3,  1'b1, 1'b0, 4'd5,  8'h21);
        do_cfg(7,  1'b1, 1'b1, 4'd9,  8'h40);
        do_cfg(1,  1'b1, 1'b0, 4'd2,  8'h11);
        do_cfg(10, 1'b1, 1'b0, 4'd12, 8'hA0);
        do_cfg(2,  1'b1, 1'b0, 4'd4,  8'h22);
        do_cfg(5,  1'b1, 1'b0, 4'd4,  8'h55);
        do_cfg(9,  1'b1, 1'b0, 4'd4,  8'h99);
        do_cfg(4,  1'b1, 1'b0, 4'd3,  8'h44);
        test_edge;
        test_level;
        test_priority;
        test_rr;
        test_full;
        test_cfg_disable;
        test_reset_mid;
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got %0d expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_req_collector.md
Name: int_req_collector

Overview:
- Front end of the CPU interrupt path: samples external interrupt request lines and holds pending requests per source.
- Arbitrates among pending sources by programmable priority, then round-robin within equal priority.
- Posts one 28-bit entry per cycle into the downstream int_queue through its wr / i / full interface.
- Level-triggered sources are masked after posting until an end-of-interrupt (EOI) for that source arrives, so one assertion produces exactly one entry.

Parameters:
- NSRC, 16, number of request sources (1..32).
- SRCW, 5, width of the source index field (fixed 5; holds 0..31).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- irq  input  NSRC  request lines, synchronous to clk.
- cfg_wr  input  1  configuration write strobe.
- cfg_src  input  5  source index being configured.
- cfg_dat  input  14  {en[13], lvl[12], pri[11:8], vector[7:0]}.
- eoi  input  1  end-of-interrupt strobe.
- eoi_src  input  5  source index being retired.
- full  input  1  downstream queue full.
- wr  output  1  queue write strobe.
- o  output  28  queue entry.
- pend  output  NSRC  pending bits, for status reads.

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Entry format:
  - o[27:24] = pri; 15 is highest, which matches the downstream cpri compare.
  - o[23:16] = vector.
  - o[15:5] = 0.
  - o[4:0] = source index.
- Reset:
  - wr=0, o=0, pend=0.
  - All config cleared (en=0, lvl=0, pri=0, vector=0).
  - Posted (in-service) bits cleared, previous-irq register cleared, round-robin pointer rr=0.
- Request detection, per source s with en=1:
  - Edge mode (lvl=0): set pend[s] when irq[s]=1 and prev[s]=0. prev is registered each cycle.
  - Level mode (lvl=1): set pend[s] when irq[s]=1 and posted[s]=0.
  - en=0: pend[s] is held at 0 and no new requests are set.
- Selection (combinational):
  - Candidates are sources with pend=1.
  - Winner is the highest pri; ties go to the first index at or after rr, wrapping modulo NSRC.
- Post, registered with 1-cycle latency:
  - Condition: full=0 and at least one candidate.
  - On the next edge: wr<=1, o<=entry(winner), pend[winner]<=0, rr<=winner+1 (wraps to 0 at NSRC), posted[winner]<=lvl[winner].
  - Otherwise wr<=0 and o holds its last value.
- Throughput and full:
  - One post per cycle maximum; back-to-back posts are allowed while full=0.
  - full is sampled in the selection cycle; no post is launched while full=1.
  - The downstream queue absorbs the single entry already in flight; the queue depth provides that slack.
- EOI: clears posted[eoi_src]. An eoi_src >= NSRC is ignored.
- Simultaneous events:
  - A new edge on the winner in its clear cycle leaves pend set; set wins, and a second entry is posted later.
  - EOI and a post for the same source in the same cycle leave posted=1; set wins.
  - cfg_wr with en=0 clears pend[s] and posted[s] that cycle. If that source is the current winner, the post still completes.
  - cfg_wr with en=1 does not clear pend. A changed pri applies from the next selection.
  - cfg_src >= NSRC is ignored.
- Reset asserted mid-operation: all state returns to reset values on the next edge; no wr is issued in that cycle.

Decomposition:
- Package int_pkg holds:
  - typedef int_entry_t: packed struct {pri[3:0], vector[7:0], rsvd[10:0], src[4:0]}, 28 bits.
  - typedef int_cfg_t: {en, lvl, pri, vector}.
  - Constant INT_PRI_MAX=15.
- One sub-module, int_pri_rr_arb: the combinational priority + round-robin finder.
  - Inputs: pend, pri vector, rr.
  - Outputs: valid, winner index.

Test Plan:
- Edge source 3 (pri=5, vec=0x21); pulse irq[3] for 2 cycles -> exactly one wr, with o=0x521_0003 one cycle after the pend edge.
- Level source 7 (pri=9, vec=0x40); hold irq[7] high -> one wr with o=0x940_0007. Then eoi with src 7 while still high -> second wr within 2 cycles.
- Sources 1 (pri=2) and 10 (pri=12) edge-requested in the same cycle -> source 10 posted first, then source 1 on the next cycle.
- Sources 2, 5, 9 all pri=4, requested repeatedly in the same cycle -> post order 2, 5, 9, then 2, 5, 9 again (rr rotation).
- full=1 with 3 pending -> no wr. Drop full -> 3 consecutive wr cycles in priority order, and pend returns to 0.
- Source 4 pending, then cfg_wr with en=0 before post -> no wr and pend[4]=0. Separately, rst asserted while wr=1 -> wr=0 and pend=0 on the next edge.
